// File: rtl/dmac_copy_ctrl.sv
// Single-channel DMA engine that copies a block of words between regions of the shared 64-word ram.
// Defining DMAC_FILL_EN adds a constant-fill mode (fill/fill_value ports) that writes without reading.
module dmac_copy_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  size,
`ifdef DMAC_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [2:0] {IDLE, REQ, READ, CAPT, WRITE, DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  size_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  cnt_d;
    logic [DATA_W-1:0] data_q;
    logic              last_word;
    logic              fill_mode;

`ifdef DMAC_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_value_q;
    logic              grant_seen_q;

    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    assign last_word = (cnt_q == size_q - LEN_W'(1));
    assign ram_din   = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = (size != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                if (bus_grant) begin
`ifdef DMAC_FILL_EN
                    if (!fill_q) begin
                        state_d = READ;
                    end else if (grant_seen_q) begin
                        state_d = WRITE;
                    end
`else
                    state_d = READ;
`endif
                end
            end
            READ:  state_d = CAPT;
            CAPT:  state_d = WRITE;
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = fill_mode ? WRITE : READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transfer parameters are captured only when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && start) begin
                src_q  <= src_addr;
                dst_q  <= dst_addr;
                size_q <= size;
            end
            if (state_q == CAPT) begin
                data_q <= ram_dout;
            end
`ifdef DMAC_FILL_EN
            if (state_q == REQ && state_d == WRITE) begin
                data_q <= fill_value_q;
            end
`endif
        end
    end

`ifdef DMAC_FILL_EN
    // The first fill write waits one turnaround cycle after the grant is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q       <= 1'b0;
            fill_value_q <= '0;
            grant_seen_q <= 1'b0;
        end else begin
            grant_seen_q <= (state_q == REQ) && bus_grant;
            if (state_q == IDLE && start) begin
                fill_q       <= fill;
                fill_value_q <= fill_value;
            end
        end
    end
`endif

    // Outputs are registered from the next state; the address holds whenever the ram is not enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            bus_req  <= 1'b0;
            ram_cen  <= 1'b0;
            ram_wen  <= 1'b0;
            ram_addr <= '0;
        end else begin
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            bus_req <= (state_d == REQ) || (state_d == READ) ||
                       (state_d == CAPT) || (state_d == WRITE);
            ram_cen <= (state_d == READ) || (state_d == WRITE);
            ram_wen <= (state_d == WRITE);
            if (state_d == READ) begin
                ram_addr <= src_q + ADDR_W'(cnt_d);
            end else if (state_d == WRITE) begin
                ram_addr <= dst_q + ADDR_W'(cnt_d);
            end
        end
    end

endmodule

// File: tb/tb_dmac_copy_ctrl.sv
// Self-checking bench for dmac_copy_ctrl: a 64-word ram model plus a word-level reference memory
// updated by the copy rules, with directed and randomized transfers, stalls and a mid-transfer reset.
module tb_dmac_copy_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [6:0]  size;
    logic        busy;
    logic        done;
    logic        bus_req;
    logic        bus_grant;
    logic        ram_cen;
    logic        ram_wen;
    logic [15:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
`ifdef DMAC_FILL_EN
    logic        fill;
    logic [31:0] fill_value;
`endif

    logic [31:0] mem   [64];
    logic [31:0] model [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int e0 = 0;

    dmac_copy_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .size      (size),
`ifdef DMAC_FILL_EN
        .fill      (fill),
        .fill_value(fill_value),
`endif
        .busy      (busy),
        .done      (done),
        .bus_req   (bus_req),
        .bus_grant (bus_grant),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Synchronous ram decoding addr[5:0], with a backdoor write port for preloading.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_cen) begin
            if (ram_wen) mem[ram_addr[5:0]] <= ram_din;
            else         ram_dout <= mem[ram_addr[5:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkMemory(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== model[i]) bad++;
        end
        checkOutput(tag, 64'(bad), 64'd0);
    endtask

    task automatic writeWord(input logic [5:0] a, input logic [31:0] d);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = d;
        model[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Runs one whole transfer and checks timing, bus activity and the resulting memory image.
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input int n,
                                 input int stall, input bit f, input logic [31:0] fv);
        int k;
        int done_k = -1;
        int busy_low = 0;
        int req_cyc = 0;
        int rd_cyc = 0;
        int wr_cyc = 0;
        int stall_cen = 0;
        int exp_k;
        logic [5:0] si;
        logic [5:0] di;
        src_addr = s;
        dst_addr = d;
        size = 7'(n);
        start = 1'b1;
        bus_grant = (stall == 0);
`ifdef DMAC_FILL_EN
        fill = f;
        fill_value = fv;
`endif
        e0 = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            k = edge_cnt - e0;
            bus_grant = (k >= stall);
            if (!busy) busy_low++;
            if (bus_req) req_cyc++;
            if (ram_cen && !ram_wen) rd_cyc++;
            if (ram_cen && ram_wen) wr_cyc++;
            if (k < stall && ram_cen) stall_cen++;
            if (done) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            si = s[5:0] + 6'(i);
            di = d[5:0] + 6'(i);
            model[di] = f ? fv : model[si];
        end
        exp_k = (n == 0) ? 0 : (f ? n + 2 + stall : 3 * n + 1 + stall);
        checkOutput("done_cycle", 64'(done_k), 64'(exp_k));
        checkOutput("busy_low", 64'(busy_low), 64'd0);
        checkOutput("bus_req_cycles", 64'(req_cyc), 64'(exp_k));
        checkOutput("read_cycles", 64'(rd_cyc), f ? 64'd0 : 64'(n));
        checkOutput("write_cycles", 64'(wr_cyc), 64'(n));
        checkOutput("cen_in_stall", 64'(stall_cen), 64'd0);
        @(negedge clk);
        checkOutput("after_done", {62'd0, done, busy}, 64'd0);
        checkMemory("memory");
    endtask

    initial begin
        logic [15:0] rs;
        logic [15:0] rd;
        reset_n = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        size = '0;
        bus_grant = 1'b0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
`ifdef DMAC_FILL_EN
        fill = 1'b0;
        fill_value = '0;
`endif
        @(negedge clk);
        checkOutput("reset_outputs",
                    {11'd0, busy, done, bus_req, ram_cen, ram_wen, ram_addr, ram_din}, 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 64; i++) writeWord(6'(i), $urandom);
        $display("[TB] memory preloaded");

        for (int i = 0; i < 4; i++) writeWord(6'(i), 32'(i + 1));
        applyStimulus(16'd0, 16'd16, 4, 0, 1'b0, 32'd0);
        checkOutput("basic_word3", {32'd0, mem[19]}, 64'd4);

        applyStimulus(16'd0, 16'd16, 4, 5, 1'b0, 32'd0);

        applyStimulus(16'd5, 16'd20, 0, 0, 1'b0, 32'd0);

        writeWord(6'd62, 32'hAAAA_0001);
        writeWord(6'd63, 32'hBBBB_0002);
        writeWord(6'd0,  32'hCCCC_0003);
        writeWord(6'd1,  32'hDDDD_0004);
        applyStimulus(16'd62, 16'd30, 4, 0, 1'b0, 32'd0);
        checkOutput("wrap_word2", {32'd0, mem[32]}, 64'hCCCC_0003);

        applyStimulus(16'd40, 16'd41, 5, 1, 1'b0, 32'd0);

        // Reset during the second word's capture cycle.
        src_addr = 16'd0;
        dst_addr = 16'd48;
        size = 7'd4;
        start = 1'b1;
        bus_grant = 1'b1;
        e0 = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && (edge_cnt - e0) < 5; i++) @(negedge clk);
        checkOutput("capt2_idle_ram", {63'd0, ram_cen}, 64'd0);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset",
                    {11'd0, busy, done, bus_req, ram_cen, ram_wen, ram_addr, ram_din}, 64'd0);
        model[48] = model[0];
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_no_done", {63'd0, done}, 64'd0);
        checkMemory("reset_memory");
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'd0, 16'd48, 4, 0, 1'b0, 32'd0);

        for (int t = 0; t < 6; t++) begin
            rs = 16'($urandom);
            rd = 16'($urandom);
            applyStimulus(rs, rd, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                          1'b0, 32'd0);
        end

`ifdef DMAC_FILL_EN
        applyStimulus(16'd0, 16'd8, 3, 0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(16'($urandom), 16'($urandom), int'($urandom_range(1, 8)),
                      int'($urandom_range(0, 3)), 1'b1, $urandom);
        applyStimulus(16'd3, 16'd50, 3, 0, 1'b0, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
